// File: rtl/apb4_dual_arbiter_if.sv
// apb4_dual_arbiter_if: APB4 bus bundle between the arbiter (master side)
// and the shared register slave.
interface apb4_dual_arbiter_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [31:0]          pwdata;
    logic [3:0]           pstrb;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_dual_arbiter.sv
// apb4_dual_arbiter: shares one APB4 slave port between two req/done
// requesters with round-robin grant and full SETUP/ACCESS sequencing.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT cycles without pready (completes with err=1, rdata=0).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus idle, arbitrate and latch the winner's transfer fields
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout when enabled)
// DONE   | one-cycle done pulse to the granted requester
module apb4_dual_arbiter #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,

    input  logic                 rq0_req,
    input  logic                 rq0_write,
    input  logic [ADDRWIDTH-1:0] rq0_addr,
    input  logic [31:0]          rq0_wdata,
    input  logic [3:0]           rq0_strb,
    output logic                 rq0_done,
    output logic [31:0]          rq0_rdata,
    output logic                 rq0_err,

    input  logic                 rq1_req,
    input  logic                 rq1_write,
    input  logic [ADDRWIDTH-1:0] rq1_addr,
    input  logic [31:0]          rq1_wdata,
    input  logic [3:0]           rq1_strb,
    output logic                 rq1_done,
    output logic [31:0]          rq1_rdata,
    output logic                 rq1_err,

    apb4_dual_arbiter_if.master  apb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // TIMEOUT feeds an 8-bit counter, so reject values it cannot hold.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("apb4_dual_arbiter: TIMEOUT must be within 2..255");
    end

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_grant_q, last_grant_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [31:0]          rd0_q, rd0_d;
    logic [31:0]          rd1_q, rd1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;
`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0]           tmo_q, tmo_d;
`endif

    // Winner selection and field mux; 1 selects requester 1.
    logic                 pick_rq1;
    logic                 sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_strb;

    logic                 cap_en;
    logic [31:0]          cap_data;
    logic                 cap_err;

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        pick_rq1  = rq1_req && (!rq0_req || !last_grant_q);
        sel_write = pick_rq1 ? rq1_write : rq0_write;
        sel_addr  = pick_rq1 ? rq1_addr  : rq0_addr;
        sel_wdata = pick_rq1 ? rq1_wdata : rq0_wdata;
        sel_strb  = pick_rq1 ? rq1_strb  : rq0_strb;
    end

    // Next-state, bus field latching and per-requester completion capture.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        cap_en       = 1'b0;
        cap_data     = 32'h0;
        cap_err      = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                if (rq0_req || rq1_req) begin
                    gnt_d        = pick_rq1;
                    last_grant_d = pick_rq1;
                    pwrite_d     = sel_write;
                    paddr_d      = sel_addr;
                    pwdata_d     = sel_wdata;
                    pstrb_d      = sel_write ? sel_strb : 4'b0000;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                tmo_d   = 8'(TIMEOUT - 1);
`endif
            end
            ACCESS: begin
                if (apb.pready) begin
                    cap_en   = 1'b1;
                    cap_data = pwrite_q ? 32'h0 : apb.prdata;
                    cap_err  = apb.pslverr;
                    state_d  = DONE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_q == 8'd0) begin
                    cap_en   = 1'b1;
                    cap_data = 32'h0;
                    cap_err  = 1'b1;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_en) begin
            if (gnt_q) begin
                rd1_d  = cap_data;
                err1_d = cap_err;
            end else begin
                rd0_d  = cap_data;
                err0_d = cap_err;
            end
        end
    end

    // State and datapath registers; reset leaves rq0 first in line.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= 32'h0;
            pstrb_q      <= 4'b0000;
            rd0_q        <= 32'h0;
            rd1_q        <= 32'h0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS watchdog: loaded in SETUP, counts down while pready stays low.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb.penable = (state_q == ACCESS);
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;

    assign rq0_done  = (state_q == DONE) && !gnt_q;
    assign rq1_done  = (state_q == DONE) &&  gnt_q;
    assign rq0_rdata = rd0_q;
    assign rq1_rdata = rd1_q;
    assign rq0_err   = err0_q;
    assign rq1_err   = err1_q;

endmodule

// File: tb/tb_apb4_dual_arbiter.sv
// tb_apb4_dual_arbiter: transaction-timeline model of the arbiter with a
// scripted/random APB slave; every cycle the DUT outputs are compared.
module tb_apb4_dual_arbiter;
    localparam int AW  = 12;
    localparam int TMO = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb4_dual_arbiter_if #(.ADDRWIDTH(AW)) apb ();

    logic          rq0_req = 1'b0, rq0_write = 1'b0, rq1_req = 1'b0, rq1_write = 1'b0;
    logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
    logic [31:0]   rq0_wdata = '0, rq1_wdata = '0;
    logic [3:0]    rq0_strb = '0, rq1_strb = '0;
    logic          rq0_done, rq1_done, rq0_err, rq1_err;
    logic [31:0]   rq0_rdata, rq1_rdata;

    apb4_dual_arbiter #(.ADDRWIDTH(AW), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_strb(rq0_strb), .rq0_done(rq0_done),
        .rq0_rdata(rq0_rdata), .rq0_err(rq0_err),
        .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_strb(rq1_strb), .rq1_done(rq1_done),
        .rq1_rdata(rq1_rdata), .rq1_err(rq1_err),
        .apb(apb)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // requester side
    logic          r_req [2];
    logic          r_write [2];
    logic [AW-1:0] r_addr [2];
    logic [31:0]   r_wdata [2];
    logic [3:0]    r_strb [2];
    bit rand_en = 0, hold_en = 0, rst_req = 1;

    // slave scripting
    int          force_w = -1;
    int          force_err = -1;
    bit          use_rd = 0;
    logic [31:0] force_rd = '0;
    bit          force_stuck = 0;

    // model: one transfer occupies cycles s (grant) .. s+3+w (done)
    bit            act = 0;
    int            s = 0, w = 0, own = 0;
    bit            last = 1;
    logic          t_write, t_err, t_stuck;
    logic [AW-1:0] t_addr;
    logic [31:0]   t_wdata, t_rd;
    logic [3:0]    t_strb;
    logic          e_pwrite;
    logic [AW-1:0] e_paddr;
    logic [31:0]   e_pwdata;
    logic [3:0]    e_pstrb;
    logic [31:0]   e_rdata [2];
    logic          e_err [2];

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        act = 0; last = 1;
        e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
        for (int i = 0; i < 2; i++) begin e_rdata[i] = '0; e_err[i] = 0; end
    endtask

    task automatic rand_raise(input int i);
        r_req[i]   = 1'b1;
        r_write[i] = 1'($urandom_range(0, 1));
        r_addr[i]  = AW'($urandom);
        r_wdata[i] = $urandom;
        r_strb[i]  = 4'($urandom);
    endtask

    task automatic step();
        int rel;
        bit e_psel, e_pen, just_done, rdy;
        @(negedge pclk);
        cyc++;
        just_done = 0;
        rel    = act ? (cyc - s) : -1;
        e_psel = act && rel >= 1 && rel <= 2 + w;
        e_pen  = act && rel >= 2 && rel <= 2 + w;
        if (act && rel == 1) begin
            e_pwrite = t_write; e_paddr = t_addr; e_pwdata = t_wdata; e_pstrb = t_strb;
        end
        if (act && rel == 3 + w) begin
            just_done    = 1;
            e_rdata[own] = t_write ? 32'h0 : t_rd;
            e_err[own]   = t_err;
        end
        chk("psel", 32'(apb.psel), 32'(e_psel));
        chk("penable", 32'(apb.penable), 32'(e_pen));
        chk("pwrite", 32'(apb.pwrite), 32'(e_pwrite));
        chk("paddr", 32'(apb.paddr), 32'(e_paddr));
        chk("pwdata", apb.pwdata, e_pwdata);
        chk("pstrb", 32'(apb.pstrb), 32'(e_pstrb));
        chk("rq0_done", 32'(rq0_done), 32'(just_done && own == 0));
        chk("rq1_done", 32'(rq1_done), 32'(just_done && own == 1));
        chk("rq0_rdata", rq0_rdata, e_rdata[0]);
        chk("rq1_rdata", rq1_rdata, e_rdata[1]);
        chk("rq0_err", 32'(rq0_err), 32'(e_err[0]));
        chk("rq1_err", 32'(rq1_err), 32'(e_err[1]));

        if (just_done) begin act = 0; r_req[own] = 1'b0; end
        for (int i = 0; i < 2; i++)
            if (!r_req[i] && (hold_en || (rand_en && $urandom_range(0, 2) == 0)))
                rand_raise(i);

        if (rst_req) model_reset();
        rdy = act && !t_stuck && (cyc - s) == 2 + w;
        apb.pready  = rdy;
        apb.prdata  = rdy ? t_rd : $urandom;
        apb.pslverr = rdy ? t_err : 1'($urandom_range(0, 1));
        presetn     = !rst_req;
        rq0_req = r_req[0]; rq0_write = r_write[0]; rq0_addr = r_addr[0];
        rq0_wdata = r_wdata[0]; rq0_strb = r_strb[0];
        rq1_req = r_req[1]; rq1_write = r_write[1]; rq1_addr = r_addr[1];
        rq1_wdata = r_wdata[1]; rq1_strb = r_strb[1];

        if (!rst_req && !act && !just_done && (r_req[0] || r_req[1])) begin
            own     = (r_req[0] && r_req[1]) ? (last ? 0 : 1) : (r_req[1] ? 1 : 0);
            last    = (own == 1);
            act     = 1;
            s       = cyc;
            t_write = r_write[own];
            t_addr  = r_addr[own];
            t_wdata = r_wdata[own];
            t_strb  = r_write[own] ? r_strb[own] : 4'b0000;
            if (force_stuck) begin
                t_stuck = 1;
`ifdef APB_ARB_TIMEOUT_EN
                w = TMO - 1; t_rd = '0; t_err = 1;
`else
                w = 1 << 20; t_rd = '0; t_err = 0;
`endif
            end else begin
                t_stuck = 0;
                w       = (force_w >= 0) ? force_w : $urandom_range(0, 3);
                t_rd    = use_rd ? force_rd : $urandom;
                t_err   = (force_err >= 0) ? 1'(force_err) : ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic wait_done(input int i, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            step();
            if ((i == 0 ? rq0_done : rq1_done) === 1'b1) begin at = cyc; break; end
        end
        total++;
        if (at < 0) begin
            bad++;
            $display("FAIL wait_done rq%0d: no done within %0d cycles", i, bound);
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((act || r_req[0] || r_req[1]) && n < bound) begin step(); n++; end
        total++;
        if (act || r_req[0] || r_req[1]) begin
            bad++;
            $display("FAIL drain: requests still pending after %0d cycles", bound);
        end
    endtask

    initial begin
        int t0, at, n;
        int order [4];
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 0; r_write[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0;
        end
        apb.pready = 0; apb.prdata = '0; apb.pslverr = 0;
        model_reset();

        // reset values
        step(); step();
        chk("rst_psel", 32'(apb.psel), 32'h0);
        chk("rst_penable", 32'(apb.penable), 32'h0);
        chk("rst_paddr", 32'(apb.paddr), 32'h0);
        chk("rst_done", 32'({rq0_done, rq1_done}), 32'h0);
        chk("rst_rdata", rq0_rdata | rq1_rdata, 32'h0);
        rst_req = 0;
        step(); step();

        // rq0 zero-wait write
        r_req[0] = 1; r_write[0] = 1; r_addr[0] = 12'h004; r_wdata[0] = 32'hA5A5_1234;
        r_strb[0] = 4'b0011; force_w = 0; force_err = 0;
        step(); t0 = cyc;
        step();
        chk("wr_setup_psel", 32'({apb.psel, apb.penable}), 32'h2);
        chk("wr_pwrite", 32'(apb.pwrite), 32'h1);
        chk("wr_paddr", 32'(apb.paddr), 32'h004);
        chk("wr_pstrb", 32'(apb.pstrb), 32'h3);
        wait_done(0, 20, at);
        chk("wr_latency", 32'(at - t0), 32'd3);
        chk("wr_err", 32'(rq0_err), 32'h0);
        step();

        // rq1 read with two wait states
        r_req[1] = 1; r_write[1] = 0; r_addr[1] = 12'h008; r_wdata[1] = 32'h1111_2222;
        r_strb[1] = 4'b1111; force_w = 2; use_rd = 1; force_rd = 32'hDEAD_BEEF;
        step(); t0 = cyc;
        step();
        chk("rd_pstrb", 32'(apb.pstrb), 32'h0);
        chk("rd_paddr", 32'(apb.paddr), 32'h008);
        wait_done(1, 20, at);
        chk("rd_latency", 32'(at - t0), 32'd5);
        chk("rd_rdata", rq1_rdata, 32'hDEAD_BEEF);
        use_rd = 0; force_w = -1; force_err = -1;
        step();

        // both requesting continuously: strict alternation
        for (int k = 0; k < 4; k++) order[k] = -1;
        hold_en = 1; n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            step();
            if (rq0_done === 1'b1) begin order[n] = 0; n++; end
            else if (rq1_done === 1'b1) begin order[n] = 1; n++; end
        end
        hold_en = 0;
        for (int k = 0; k < 4; k++) chk("rr_order", 32'(order[k]), 32'(k % 2));
        drain(100);
        step();

        // slave error on read, then cleared by a clean transfer
        r_req[0] = 1; r_write[0] = 0; r_addr[0] = 12'h010; force_w = 1; force_err = 1;
        wait_done(0, 20, at);
        chk("err_set", 32'(rq0_err), 32'h1);
        step();
        r_req[0] = 1; r_write[0] = 1; r_addr[0] = 12'h014; r_wdata[0] = 32'h0BAD_F00D;
        force_w = 0; force_err = 0;
        wait_done(0, 20, at);
        chk("err_clear", 32'(rq0_err), 32'h0);
        chk("err_clear_rdata", rq0_rdata, 32'h0);
        step();

        // reset during ACCESS with both requesters pending
        r_req[1] = 1; r_write[1] = 1; r_addr[1] = 12'h020;
        force_w = 5; force_err = -1;
        step(); step(); step();
        chk("mid_access", 32'({apb.psel, apb.penable}), 32'h3);
        rand_raise(0);
        rst_req = 1;
        step(); step();
        chk("mid_rst_bus", 32'({apb.psel, apb.penable}), 32'h0);
        chk("mid_rst_done", 32'({rq0_done, rq1_done}), 32'h0);
        force_w = 0;
        rst_req = 0;
        step(); t0 = cyc;
        wait_done(0, 20, at);
        chk("post_rst_rq0_first", 32'(at - t0), 32'd3);
        drain(50);
        force_w = -1;
        step();

        // slave never ready
        force_stuck = 1;
        r_req[1] = 1; r_write[1] = 0; r_addr[1] = 12'h030;
        step(); t0 = cyc;
`ifdef APB_ARB_TIMEOUT_EN
        wait_done(1, 40, at);
        chk("tmo_latency", 32'(at - t0), 32'(2 + TMO));
        chk("tmo_err", 32'(rq1_err), 32'h1);
        chk("tmo_rdata", rq1_rdata, 32'h0);
        force_stuck = 0;
        step();
`else
        for (int k = 0; k < 100; k++) step();
        chk("stuck_access", 32'({apb.psel, apb.penable}), 32'h3);
        chk("stuck_no_done", 32'({rq0_done, rq1_done}), 32'h0);
        rst_req = 1;
        step(); step();
        r_req[1] = 0; force_stuck = 0;
        rst_req = 0;
        step();
`endif

        // randomized traffic
        rand_en = 1;
        for (int k = 0; k < 3000; k++) step();
        rand_en = 0;
        drain(100);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb4_dual_arbiter.md
# apb4_dual_arbiter

Two-requester APB4 master arbiter that shares the single APB4 register slave port among two internal requesters. Each requester issues one read or write through a simple req/done handshake. The arbiter grants round-robin, sequences the APB4 SETUP/ACCESS phases and honours slave wait states. It returns read data and slave error to the granted requester.

## Interface
- ADDRWIDTH, 12, APB address width (matches slave)
- TIMEOUT, 16, max ACCESS cycles without pready (used only with timeout macro); range 2..255

- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- rqN_req  in  1  requester N (N=0,1) transfer request; held until rqN_done
- rqN_write  in  1  1-write 0-read; stable while rqN_req
- rqN_addr  in  ADDRWIDTH  byte address; stable while rqN_req
- rqN_wdata  in  32  write data; stable while rqN_req
- rqN_strb  in  4  write byte enables; stable while rqN_req
- rqN_done  out  1  one-cycle completion pulse
- rqN_rdata  out  32  read data, valid with rqN_done (0 for writes)
- rqN_err  out  1  error flag, valid with rqN_done
- psel  out  1  APB4 select
- penable  out  1  APB4 enable
- pwrite  out  1  APB4 direction
- paddr  out  ADDRWIDTH  APB4 address
- pwdata  out  32  APB4 write data
- pstrb  out  4  APB4 strobes
- prdata  in  32  APB4 read data
- pready  in  1  APB4 ready
- pslverr  in  1  APB4 error

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: psel=0, penable=0. Grant follows these rules:
  - Only one rqN_req high: grant it.
  - Both high: grant the requester not served last (last_grant, reset=1, so rq0 wins first).
  - On grant, register write/addr/wdata/strb onto APB outputs, update last_grant, go to SETUP.
- SETUP: psel=1, penable=0, one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. Hold until pready=1. Then capture prdata (reads) or 0 (writes) plus pslverr into granted rqN_rdata/rqN_err, and go to DONE.
- DONE: granted rqN_done=1 for exactly one cycle, then IDLE. Requester drops req the edge after done. A still-high req is treated as a new request.
- pstrb forced 4'b0000 on reads. paddr/pwrite/pwdata/pstrb held constant from SETUP through end of ACCESS. They keep their last value in IDLE/DONE.
- rqN_rdata/rqN_err hold their value until that requester's next completion. The non-granted requester's outputs are untouched.
- Requests arriving during SETUP/ACCESS/DONE wait. No request is dropped.
- Address alignment is not checked. Bits are passed through.

## Timing
- Reset: state IDLE, all outputs 0 (psel, penable, pwrite, paddr, pwdata, pstrb, rqN_done, rqN_rdata, rqN_err), last_grant=1.
- Zero-wait transfer: req seen in IDLE at cycle T gives SETUP at T+1, ACCESS at T+2 (pready=1), and done at T+3. Each wait cycle adds 1. Minimum 4 cycles per transfer.
- Both requesters continuously requesting: strict alternation rq0, rq1, rq0, ...
- Reset mid-transfer: immediate abort, no rqN_done issued, outputs to reset values.

## Configuration
- APB_ARB_TIMEOUT_EN defined: an 8-bit counter counts ACCESS cycles with pready=0.
  - On reaching TIMEOUT, go to DONE with rqN_err=1 and rqN_rdata=0.
  - psel/penable drop in the DONE cycle.
  - The counter clears on entry to ACCESS.
- Not defined: ACCESS waits indefinitely for pready. TIMEOUT is unused and no counter logic exists.

## Test plan
- rq0 write addr 0x004 wdata 0xA5A5_1234 strb 4'b0011, pready=1 -> SETUP/ACCESS on pwrite=1 paddr=0x004 pstrb=0011, rq0_done 3 cycles after req, rq0_err=0.
- rq1 read addr 0x008, slave drives prdata=0xDEAD_BEEF after 2 wait cycles -> pstrb=0000, rq1_done at T+5, rq1_rdata=0xDEAD_BEEF.
- rq0 and rq1 raised same cycle, held 4 transfers -> order rq0, rq1, rq0, rq1; only one done per transfer.
- Read with pslverr=1 on the pready cycle -> rq0_err=1 with rq0_done; next error-free transfer clears it.
- presetn low during ACCESS -> psel/penable=0 next cycle, no done. After release, the pending req restarts from IDLE with rq0 priority.
- APB_ARB_TIMEOUT_EN, TIMEOUT=16, pready stuck 0 -> done with err=1 and rdata=0 after 16 ACCESS cycles. Without the macro, still in ACCESS at cycle 100.
